// File: rtl/spi_flash_fetch_pkg.sv
// Shared definitions for the SPI flash word fetcher: read command, FSM
// states, field and counter widths, and the flash-to-core byte reordering.
// No ports; imported by the interface, the SCK divider and the top.
package spi_flash_fetch_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam int ADDR_W    = 24;  // flash byte address
  localparam int DATA_W    = 32;  // fetched word
  localparam int TX_BITS   = 32;  // command + address shifted out on MOSI
  localparam int BIT_CNT_W = 6;   // counts the 64 bit periods of a transaction
  localparam int DIV_CNT_W = 4;   // CLK_DIV up to 16
  localparam int GAP_CNT_W = 4;   // CS_HIGH up to 15

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Flash streams B0 (lowest address) first; the core wants it in the LSBs.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_fetch_if.sv
// Core-side fetch port: request handshake, flush, and the response word.
// Latency/backpressure are set by the slave; req_ready stalls the master.
// Ports: req_valid/req_ready/req_addr, flush, rsp_valid/rsp_data.
interface spi_flash_fetch_if;
  import spi_flash_fetch_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, flush,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, flush,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spi_flash_fetch_sck_gen.sv
// SPI mode-0 clock divider: sck low CLK_DIV cycles, then high CLK_DIV cycles.
// Strobes rise/fall are combinational and mark the edge that toggles sck.
// Ports: clk, rst, en (low parks sck at 0 on the next edge), sck, rise, fall.
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  import spi_flash_fetch_pkg::*;

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 wrap;

  assign wrap = en && (div_cnt == DIV_LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      // Disabling always restarts a fresh low half-period.
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_fetch.sv
// SPI flash 32-bit fetch engine: READ (0x03) + 24-bit address, 32 data bits.
// Latency: accept at cycle 0 -> rsp_valid at cycle 1+128*CLK_DIV.
// Backpressure: req_ready only while idle; flush aborts, CS_HIGH gap enforced.
// Ports: clk, rst, bus (core side, slave modport), spi_csb/sck/mosi/miso.
module spi_flash_fetch #(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_flash_fetch_if.slave   bus,
  output logic               spi_csb,
  output logic               spi_sck,
  output logic               spi_mosi,
  input  logic               spi_miso
);
  import spi_flash_fetch_pkg::*;

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(CS_HIGH - 1);

  state_e               state;
  state_e               state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [TX_BITS-1:0]   tx_sr;
  logic [DATA_W-1:0]    rx_sr;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 rsp_valid_q;
  logic                 accept;
  logic                 sck_en;
  logic                 rise;
  logic                 fall;
  logic                 last_fall;

  assign accept    = (state == IDLE) && bus.req_valid;
  // Flush stops the divider so sck drops on the same edge csb rises.
  assign sck_en    = (state == SHIFT) && !bus.flush;
  // fall is gated by sck_en, so a flush in the final cycle suppresses this.
  assign last_fall = fall && (bit_cnt == '1);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign spi_csb       = (state != SHIFT);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid)             state_nxt = SHIFT;
      SHIFT:   if (bus.flush || last_fall)    state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST)       state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;

      case (state)
        IDLE: begin
          if (accept) begin
            // First MOSI bit goes out with csb falling; the rest sit in tx_sr
            // and shift in zeros, which become the idle-low read phase.
            spi_mosi <= FLASH_CMD_READ[7];
            tx_sr    <= {FLASH_CMD_READ[6:0], bus.req_addr, 1'b0};
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            spi_mosi <= 1'b0;
          end else begin
            // bit_cnt[5] set means periods 32..63: the read half.
            if (rise && bit_cnt[BIT_CNT_W-1])
              rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
            if (fall) begin
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= tx_sr[TX_BITS-1];
              tx_sr    <= {tx_sr[TX_BITS-2:0], 1'b0};
            end
            if (last_fall) begin
              spi_mosi    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= byte_swap(rx_sr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_flash_fetch.md
SPI_FLASH_FETCH -- requirements
Module: spi_flash_fetch

Interface
REQ-001 Parameter CLK_DIV, default 1: SCK half-period in clk cycles (legal 1..16).
REQ-002 Parameter CS_HIGH, default 2: minimum csb-high clk cycles between transactions (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  core requests a 32-bit fetch.
REQ-006 req_ready  output  1  block idle; request accepted when req_valid && req_ready.
REQ-007 req_addr  input  24  flash byte address, sampled at acceptance.
REQ-008 flush  input  1  abort any in-flight transaction (branch redirect).
REQ-009 rsp_valid  output  1  one-cycle pulse, rsp_data valid.
REQ-010 rsp_data  output  32  fetched word, held stable until next rsp_valid.
REQ-011 spi_csb  output  1  flash chip select, active low (to uo_out[6]).
REQ-012 spi_sck  output  1  flash serial clock, mode 0 (to uo_out[5]).
REQ-013 spi_mosi  output  1  flash io0 (to uo_out[7]).
REQ-014 spi_miso  input  1  flash io1 (from ui_in[7]).

Function
REQ-015 FSM states: IDLE, SHIFT, GAP; req_ready=1 only in IDLE.
REQ-016 Acceptance in IDLE moves to SHIFT; spi_csb goes low the next cycle.
REQ-017 SHIFT sends 64 bit periods: command 0x03 (8 bits), req_addr (24 bits), then 32 read bits; all fields MSB first.
REQ-018 Each bit period lasts 2*CLK_DIV clk cycles: sck low for the first CLK_DIV cycles, high for the last CLK_DIV cycles.
REQ-019 spi_mosi changes only while sck is low; during read bits spi_mosi is 0.
REQ-020 spi_miso is sampled on the clk edge that drives sck from low to high, in read bits only.
REQ-021 Byte order is little-endian: flash bytes B0..B3 at addr..addr+3 give rsp_data = {B3,B2,B1,B0}.
REQ-022 After the 64th period, in the same cycle: spi_csb=1, sck=0, rsp_valid=1, rsp_data updated; FSM enters GAP.
REQ-023 Latency: acceptance at cycle 0 gives rsp_valid at cycle 1+128*CLK_DIV.
REQ-024 GAP lasts CS_HIGH cycles with csb=1; the FSM then returns to IDLE.
REQ-025 flush in SHIFT: next cycle csb=1, sck=0, no rsp_valid for that request; FSM enters GAP.
REQ-026 flush in the final SHIFT cycle wins: no rsp_valid is produced.
REQ-027 flush in IDLE or GAP has no effect; a request presented with flush in IDLE is still accepted.
REQ-028 req_addr wraps modulo 2^24; no alignment check is applied.

Reset
REQ-029 rst forces IDLE immediately (asynchronously): spi_csb=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_data=0, req_ready=1 after release.
REQ-030 rst asserted mid-transaction abandons it; no rsp_valid is produced for the abandoned request.

Structure
REQ-031 A shared package holds the command constant FLASH_CMD_READ=8'h03, the FSM state enum, and the bit-count widths.
REQ-032 One sub-module, spi_sck_gen, implements the CLK_DIV divider and emits rise/fall strobes; the remaining logic stays flat.

Verification
REQ-033 With the spiflash model loaded with 0x00:{13,00,00,00} and CLK_DIV=1, request addr 0x000000 -> csb low for 128 cycles, then rsp_data=0x00000013, rsp_valid at cycle 129.
REQ-034 Same request with CLK_DIV=4 -> rsp_valid at cycle 513; sck period is 8 clk cycles.
REQ-035 Monitor MOSI over the first 32 sck rises for addr 0x123456 -> bit sequence 0x03123456.
REQ-036 Assert flush at bit 40 of a transaction -> csb high next cycle, no rsp_valid, req_ready after CS_HIGH cycles; a following fetch of 0x000004 returns the correct word.
REQ-037 Issue back-to-back requests with req_valid held high -> minimum csb-high gap of CS_HIGH cycles, and both words are correct.
REQ-038 Pulse rst mid-address phase -> csb=1 and sck=0 in the same cycle, no rsp_valid, next request completes normally.
